// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-requester one-deep holding slots, round-robin
// grant, branch-flush kill filtering and a registered CDB broadcast.
package cdb_arbiter_pkg;
  localparam int BR_TAG_W = 3;

  typedef struct packed {
    logic                sign;
    logic [BR_TAG_W-1:0] tag;
  } branch_tag_t;
endpackage

module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int ROB_WIDTH = 3,
  localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CDB_W     = 1 + ROB_WIDTH + 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  branch_tag_t                         flush_tag,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0][ROB_WIDTH-1:0]   req_dest_ROB,
  input  logic [NUM_REQ-1:0][31:0]            req_rd_v,
  input  branch_tag_t [NUM_REQ-1:0]           req_br_tag,
  output logic [NUM_REQ-1:0]                  req_busy,
  output logic [CDB_W-1:0]                    CDB_value,
  output logic [IDX_W-1:0]                    grant_idx
);

  // CDB_value layout, MSB first: {commit_valid, dest_ROB, rd_v}
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

  logic [NUM_REQ-1:0]                r_valid;
  logic [NUM_REQ-1:0][ROB_WIDTH-1:0] r_dest;
  logic [NUM_REQ-1:0][31:0]          r_rd;
  branch_tag_t [NUM_REQ-1:0]         r_tag;
  logic [IDX_W-1:0]                  r_ptr;
  logic [CDB_W-1:0]                  r_cdb;

  logic [NUM_REQ-1:0] w_slot_kill;
  logic [NUM_REQ-1:0] w_req_kill;
  logic [NUM_REQ-1:0] w_live;
  logic [NUM_REQ-1:0] w_grant_vec;
  logic [NUM_REQ-1:0] w_load;
  logic               w_grant_any;
  logic [IDX_W-1:0]   w_gidx;
  logic [IDX_W-1:0]   w_ptr_next;

  function automatic logic f_killed(input branch_tag_t t, input branch_tag_t f);
    logic v_hit;
    if (t.sign == f.sign) begin
      v_hit = ((t.tag & f.tag) == f.tag);
    end else begin
      v_hit = ((t.tag & f.tag) == t.tag);
    end
    return v_hit;
  endfunction

  // flush kill masks for held slots and for incoming requests
  always_comb begin
    w_slot_kill = '0;
    w_req_kill  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_slot_kill[i] = flush & r_valid[i] & f_killed(r_tag[i], flush_tag);
      w_req_kill[i]  = flush & f_killed(req_br_tag[i], flush_tag);
    end
  end

  assign w_live = r_valid & ~w_slot_kill;

  // round-robin search upward from r_ptr, first live slot wins
  always_comb begin
    logic [IDX_W:0]   v_sum;
    logic [IDX_W-1:0] v_idx;
    logic             v_take;
    w_grant_any = 1'b0;
    w_gidx      = '0;
    v_sum       = '0;
    v_idx       = '0;
    v_take      = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      v_sum       = {1'b0, r_ptr} + (IDX_W + 1)'(k);
      v_sum       = (v_sum >= NUM_REQ_W) ? (v_sum - NUM_REQ_W) : v_sum;
      v_idx       = v_sum[IDX_W-1:0];
      v_take      = ~w_grant_any & w_live[v_idx];
      w_gidx      = v_take ? v_idx : w_gidx;
      w_grant_any = w_grant_any | v_take;
    end
  end

  assign w_grant_vec = NUM_REQ'(w_grant_any) << w_gidx;
  assign w_ptr_next  = (w_gidx == LAST_IDX) ? '0 : (w_gidx + 1'b1);
  // a slot being granted this cycle frees up in time to take a back-to-back result
  assign w_load      = req_valid & (~r_valid | w_grant_vec) & ~w_req_kill;

  assign req_busy  = r_valid & ~w_grant_vec;
  assign grant_idx = w_gidx;
  assign CDB_value = r_cdb;

  // slot capture/release, pointer advance and CDB broadcast register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= '0;
      r_dest  <= '0;
      r_rd    <= '0;
      r_tag   <= '0;
      r_ptr   <= '0;
      r_cdb   <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_load[i]) begin
          r_valid[i] <= 1'b1;
          r_dest[i]  <= req_dest_ROB[i];
          r_rd[i]    <= req_rd_v[i];
          r_tag[i]   <= req_br_tag[i];
        end else if (w_grant_vec[i] | w_slot_kill[i]) begin
          r_valid[i] <= 1'b0;
        end else begin
          r_valid[i] <= r_valid[i];
        end
      end
      if (w_grant_any) begin
        r_ptr <= w_ptr_next;
        r_cdb <= {1'b1, r_dest[w_gidx], r_rd[w_gidx]};
      end else begin
        r_ptr <= r_ptr;
        r_cdb <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: hand-derived vector table, directed corner sequences
// and randomized traffic checked against a slot/queue-level reference model.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int RW = 3;
  localparam int CW = 1 + RW + 32;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     flush;
  branch_tag_t              flush_tag;
  logic [N-1:0]             req_valid;
  logic [N-1:0][RW-1:0]     req_dest_ROB;
  logic [N-1:0][31:0]       req_rd_v;
  branch_tag_t [N-1:0]      req_br_tag;
  logic [N-1:0]             req_busy;
  logic [CW-1:0]            CDB_value;
  logic [1:0]               grant_idx;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_REQ(N), .ROB_WIDTH(RW)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .flush_tag    (flush_tag),
    .req_valid    (req_valid),
    .req_dest_ROB (req_dest_ROB),
    .req_rd_v     (req_rd_v),
    .req_br_tag   (req_br_tag),
    .req_busy     (req_busy),
    .CDB_value    (CDB_value),
    .grant_idx    (grant_idx)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  bit              m_valid [N];
  logic [RW-1:0]   m_dest  [N];
  logic [31:0]     m_rd    [N];
  branch_tag_t     m_tag   [N];
  int              m_ptr;
  logic [CW-1:0]   m_cdb;
  logic [N-1:0]    e_busy;
  bit              e_gv;
  int              e_g;

  typedef struct {
    bit          r;
    bit          fl;
    logic [3:0]  ft;
    logic [3:0]  rv;
    logic [2:0]  d;
    logic [31:0] rd;
    logic [3:0]  busy;
    bit          gv;
    logic [1:0]  g;
    logic [35:0] cdb;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit kills(input branch_tag_t t, input branch_tag_t f);
    if (t.sign == f.sign) return (t.tag & f.tag) == f.tag;
    return (t.tag & f.tag) == t.tag;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    m_ptr = 0;
    m_cdb = '0;
  endtask

  task automatic model_comb();
    e_gv = 1'b0;
    e_g  = 0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (!e_gv && m_valid[idx] && !(flush && kills(m_tag[idx], flush_tag))) begin
        e_gv = 1'b1;
        e_g  = idx;
      end
    end
    for (int i = 0; i < N; i++) e_busy[i] = m_valid[i] && !(e_gv && e_g == i);
  endtask

  // compare the DUT against the model, advance the model, then take the edge
  task automatic finish_cycle();
    model_comb();
    check("busy", req_busy, e_busy);
    if (e_gv) check("grant_idx", grant_idx, e_g);
    check("cdb", CDB_value, m_cdb);
    check("protocol", req_valid & req_busy, 64'd0);
    if (!rst) begin
      model_clear();
    end else begin
      m_cdb = e_gv ? {1'b1, m_dest[e_g], m_rd[e_g]} : '0;
      if (e_gv) m_ptr = (e_g + 1) % N;
      for (int i = 0; i < N; i++) begin
        bit granted, dead, take;
        granted = e_gv && e_g == i;
        dead    = flush && m_valid[i] && kills(m_tag[i], flush_tag);
        take    = req_valid[i] && (!m_valid[i] || granted) && !(flush && kills(req_br_tag[i], flush_tag));
        if (take) begin
          m_valid[i] = 1'b1;
          m_dest[i]  = req_dest_ROB[i];
          m_rd[i]    = req_rd_v[i];
          m_tag[i]   = req_br_tag[i];
        end else if (granted || dead) begin
          m_valid[i] = 1'b0;
        end
      end
    end
    @(posedge clk);
  endtask

  // requester i gets dest d+i and value rd+i, all with branch tag bt
  task automatic drive(input bit r, input bit fl, input branch_tag_t ft, input logic [N-1:0] rv,
                       input logic [RW-1:0] d, input logic [31:0] rd, input branch_tag_t bt);
    rst       = r;
    flush     = fl;
    flush_tag = ft;
    req_valid = rv;
    for (int i = 0; i < N; i++) begin
      req_dest_ROB[i] = d + 3'(i);
      req_rd_v[i]     = rd + 32'(i);
      req_br_tag[i]   = bt;
    end
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 4'h0, 4'b0000, 3'd0, 32'h0,         4'b0000, 1'b0, 2'd0, 36'h0};
    tbl[1]  = '{1'b1, 1'b0, 4'h0, 4'b0100, 3'd3, 32'hDEADBEED,  4'b0000, 1'b0, 2'd0, 36'h0};
    tbl[2]  = '{1'b1, 1'b0, 4'h0, 4'b0000, 3'd0, 32'h0,         4'b0000, 1'b1, 2'd2, 36'h0};
    tbl[3]  = '{1'b1, 1'b0, 4'h0, 4'b0000, 3'd0, 32'h0,         4'b0000, 1'b0, 2'd0, {1'b1, 3'd5, 32'hDEADBEEF}};
    tbl[4]  = '{1'b1, 1'b0, 4'h0, 4'b0000, 3'd0, 32'h0,         4'b0000, 1'b0, 2'd0, 36'h0};
    tbl[5]  = '{1'b0, 1'b0, 4'h0, 4'b0000, 3'd0, 32'h0,         4'b0000, 1'b0, 2'd0, 36'h0};
    tbl[6]  = '{1'b1, 1'b0, 4'h0, 4'b1111, 3'd0, 32'h10000000,  4'b0000, 1'b0, 2'd0, 36'h0};
    tbl[7]  = '{1'b1, 1'b0, 4'h0, 4'b0000, 3'd0, 32'h0,         4'b1110, 1'b1, 2'd0, 36'h0};
    tbl[8]  = '{1'b1, 1'b0, 4'h0, 4'b0000, 3'd0, 32'h0,         4'b1100, 1'b1, 2'd1, {1'b1, 3'd0, 32'h10000000}};
    tbl[9]  = '{1'b1, 1'b0, 4'h0, 4'b0000, 3'd0, 32'h0,         4'b1000, 1'b1, 2'd2, {1'b1, 3'd1, 32'h10000001}};
    tbl[10] = '{1'b1, 1'b0, 4'h0, 4'b0000, 3'd0, 32'h0,         4'b0000, 1'b1, 2'd3, {1'b1, 3'd2, 32'h10000002}};
    tbl[11] = '{1'b1, 1'b0, 4'h0, 4'b0000, 3'd0, 32'h0,         4'b0000, 1'b0, 2'd0, {1'b1, 3'd3, 32'h10000003}};
    tbl[12] = '{1'b1, 1'b0, 4'h0, 4'b0000, 3'd0, 32'h0,         4'b0000, 1'b0, 2'd0, 36'h0};

    drive(1'b0, 1'b0, 4'h0, 4'b0000, 3'd0, 32'h0, 4'h0);
    repeat (2) @(posedge clk);
    model_clear();

    // single result and four-way contention
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(tbl[i].r, tbl[i].fl, tbl[i].ft, tbl[i].rv, tbl[i].d, tbl[i].rd, 4'h0);
      #1;
      check("tbl_busy", req_busy, tbl[i].busy);
      if (tbl[i].gv) check("tbl_gidx", grant_idx, tbl[i].g);
      check("tbl_cdb", CDB_value, tbl[i].cdb);
      finish_cycle();
    end

    // fairness: requesters 0 and 1 request whenever not busy
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 4'b0000, 3'd0, 32'h0, 4'h0);
    #1;
    finish_cycle();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      flush = 1'b0;
      model_comb();
      drive(1'b1, 1'b0, 4'h0, {2'b00, ~e_busy[1:0]}, 3'd0, 32'h0, 4'h0);
      #1;
      if (c >= 1) check("fair_gidx", grant_idx, (c - 1) % 2);
      finish_cycle();
    end

    // flush kills slot 1 but spares slot 2
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 4'b0000, 3'd0, 32'h0, 4'h0);
    #1;
    finish_cycle();
    @(negedge clk);
    drive(1'b1, 1'b0, 4'h0, 4'b0110, 3'd0, 32'hA0, 4'h0);
    req_br_tag[1] = {1'b0, 3'b011};
    req_br_tag[2] = {1'b0, 3'b001};
    #1;
    finish_cycle();
    @(negedge clk);
    drive(1'b1, 1'b1, {1'b0, 3'b010}, 4'b0000, 3'd0, 32'h0, 4'h0);
    #1;
    check("flush_gidx", grant_idx, 2);
    check("flush_busy", req_busy, 4'b0010);
    check("flush_cdb_hold", CDB_value, 36'h0);
    finish_cycle();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 4'h0, 4'b0000, 3'd0, 32'h0, 4'h0);
      #1;
      if (c == 0) check("flush_survivor", CDB_value, {1'b1, 3'd2, 32'hA2});
      else        check("flush_no_killed", CDB_value[CW-1], 1'b0);
      finish_cycle();
    end

    // reset with three slots held
    @(negedge clk);
    drive(1'b1, 1'b0, 4'h0, 4'b0111, 3'd4, 32'hB0, 4'h0);
    #1;
    finish_cycle();
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 4'b0000, 3'd0, 32'h0, 4'h0);
    #1;
    check("rst_busy_before", req_busy, 4'b0110);
    finish_cycle();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 4'h0, 4'b0000, 3'd0, 32'h0, 4'h0);
      #1;
      check("rst_commit", CDB_value[CW-1], 1'b0);
      check("rst_busy", req_busy, 4'b0000);
      finish_cycle();
    end

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 63) != 0);
      flush     = ($urandom_range(0, 5) == 0);
      flush_tag = 4'($urandom);
      model_comb();
      for (int i = 0; i < N; i++) begin
        req_valid[i]    = 1'($urandom_range(0, 1)) & ~e_busy[i];
        req_dest_ROB[i] = 3'($urandom);
        req_rd_v[i]     = $urandom;
        req_br_tag[i]   = 4'($urandom);
      end
      #1;
      finish_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 Parameter NUM_REQ, default 4: number of functional-unit requesters sharing the CDB.
REQ-003 Parameter ROB_WIDTH, default 3: width of ROB indices.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous, active-low reset.
REQ-006 flush  input  1  branch-mispredict flush strobe.
REQ-007 flush_tag  input  branch_tag_t  tag of the mispredicted branch, with fields sign and tag.
REQ-008 req_valid  input  NUM_REQ  requester i presents a result this cycle.
REQ-009 req_dest_ROB  input  NUM_REQ x ROB_WIDTH  destination ROB index per requester.
REQ-010 req_rd_v  input  NUM_REQ x 32  result value per requester.
REQ-011 req_br_tag  input  NUM_REQ x branch_tag_t  branch tag of each result.
REQ-012 req_busy  output  NUM_REQ  requester i SHALL NOT present a new result while high; it drives that FU's running input.
REQ-013 CDB_value  output  CDB_output_t  registered broadcast with fields commit_valid, dest_ROB and rd_v.
REQ-014 grant_idx  output  clog2(NUM_REQ)  index of the slot granted this cycle; valid only when a grant occurs.

Function
REQ-015 Each requester SHALL own a one-deep holding slot storing valid, dest_ROB, rd_v and br_tag.
REQ-016 Capture: at the clock edge, slot i SHALL load the request when req_valid[i] is high and the slot is empty or granted this cycle, unless the request is killed by flush (REQ-022).
REQ-017 req_busy[i] SHALL be combinational: slot i valid AND slot i not granted this cycle.
REQ-018 req_valid[i] while req_busy[i] is high SHALL be ignored; the bench flags it as a protocol error.
REQ-019 Arbitration SHALL be round-robin over valid, non-killed slots, searching upward from rr_ptr with wrap modulo NUM_REQ; at most one grant per cycle.
REQ-020 On a grant to index g, rr_ptr SHALL become (g+1) mod NUM_REQ; with no grant, rr_ptr SHALL hold.
REQ-021 CDB_value SHALL register the granted slot's contents with commit_valid=1; with no grant it SHALL register commit_valid=0, dest_ROB=0 and rd_v=0.
REQ-022 Kill rule: entry tag t is killed by flush_tag f when either condition holds:
- t.sign==f.sign and (t.tag & f.tag)==f.tag;
- t.sign!=f.sign and (t.tag & f.tag)==t.tag.
REQ-023 When flush is high, killed slots SHALL be invalidated at the edge, SHALL NOT be granted that cycle, and killed incoming requests SHALL NOT be captured; surviving slots arbitrate normally.
REQ-024 A flush SHALL NOT alter CDB_value already visible in the flush cycle.
REQ-025 Minimum latency: a result presented in cycle t with an empty slot SHALL appear on CDB_value in cycle t+2.
REQ-026 A granted slot receiving a new request in the same cycle SHALL capture it without a bubble, sustaining one result per cycle from a single requester when the others are idle.
REQ-027 With all NUM_REQ slots continuously valid, each requester SHALL be granted exactly once every NUM_REQ cycles.

Reset
REQ-028 While rst==0 at an edge, the following SHALL be cleared:
- all slots invalid;
- rr_ptr=0;
- CDB_value='0;
- req_busy=0 on the following cycle.
REQ-029 Reset SHALL take priority over flush and capture, and a reset mid-operation SHALL discard all held results.

Verification
REQ-030 Single result: req_valid[2]=1, dest_ROB=5, rd_v=0xDEADBEEF in cycle 1 -> CDB_value={1,5,0xDEADBEEF} in cycle 3 and req_busy[2]=0 throughout.
REQ-031 Contention: all four requests present in cycle 1 with rr_ptr=0 -> CDB_value shows slots 0,1,2,3 in cycles 3,4,5,6; req_busy[3] stays high in cycles 2-4.
REQ-032 Fairness: requesters 0 and 1 request every cycle they are not busy -> grants alternate 0,1,0,1 and neither is granted twice in a row.
REQ-033 Flush: slots 1 {sign=0, tag=0b011} and 2 {sign=0, tag=0b001} are valid, and flush is applied with flush_tag {sign=0, tag=0b010} -> slot 1 is killed and never broadcast, and slot 2 is broadcast.
REQ-034 Reset mid-operation: three slots valid and rst=0 for one cycle -> CDB_value.commit_valid=0 and req_busy=0 on the next cycle, and no stale result is ever broadcast.
